// File: rtl/pio_sw_svc_pkg.sv
// Shared types and constants for the switch-PIO interrupt service sequencer.
package pio_sw_svc_pkg;

    typedef enum logic [3:0] {
        StInitMask,
        StIdle,
        StWrMask,
        StRdEdge,
        StWaitEdge,
        StClrEdge,
        StRdData,
        StWaitData,
        StPush
    } svc_state_e;

    localparam int unsigned PIO_BUS_W = 32;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // One event record carries {edges, level}.
    function automatic int unsigned rec_width(input int unsigned data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/pio_sw_irq_service_if.sv
// Avalon-MM bus plus interrupt line between the sequencer and the switch PIO slave.
interface pio_sw_irq_service_if;
    import pio_sw_svc_pkg::*;

    logic [1:0]           pio_address;
    logic                 pio_chipselect;
    logic                 pio_write_n;
    logic [PIO_BUS_W-1:0] pio_writedata;
    logic [PIO_BUS_W-1:0] pio_readdata;
    logic                 pio_irq;

    modport master (
        output pio_address,
        output pio_chipselect,
        output pio_write_n,
        output pio_writedata,
        input  pio_readdata,
        input  pio_irq
    );

    modport slave (
        input  pio_address,
        input  pio_chipselect,
        input  pio_write_n,
        input  pio_writedata,
        output pio_readdata,
        output pio_irq
    );

endinterface

// File: rtl/pio_evt_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module pio_evt_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DepthCnt);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pio_sw_irq_service.sv
// Avalon-MM master that services switch-PIO interrupts in hardware and queues
// {edges, level} records for a valid/ready consumer.
module pio_sw_irq_service
    import pio_sw_svc_pkg::*;
#(
    parameter int unsigned        DATA_W        = 4,
    parameter int unsigned        EVT_DEPTH     = 4,
    parameter logic [DATA_W-1:0]  IRQ_MASK_INIT = DATA_W'(4'hF)
) (
    input  logic                  clk,
    input  logic                  reset,
    pio_sw_irq_service_if.master  pio,
    input  logic [DATA_W-1:0]     cfg_mask,
    input  logic                  cfg_mask_wr,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [DATA_W-1:0]     evt_edges,
    output logic [DATA_W-1:0]     evt_level,
    output logic                  evt_overflow,
    output logic                  busy
);

    localparam int unsigned RecW = rec_width(DATA_W);

    svc_state_e           state_q, state_d;
    logic [DATA_W-1:0]    mask_q;
    logic                 mask_pend_q;
    logic [DATA_W-1:0]    edges_q;
    logic [DATA_W-1:0]    level_q;
    logic                 overflow_q;

    logic [1:0]           addr_q, addr_d;
    logic                 cs_q, cs_d;
    logic                 write_n_q, write_n_d;
    logic [PIO_BUS_W-1:0] wdata_q, wdata_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 has_edges;
    logic [RecW-1:0]      fifo_rdata;
    logic                 unused_rdata;

    assign unused_rdata = ^pio.pio_readdata[PIO_BUS_W-1:DATA_W];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInitMask: state_d = StIdle;
            StIdle: begin
                if (mask_pend_q) begin
                    state_d = StWrMask;
                end else if (pio.pio_irq) begin
                    state_d = StRdEdge;
                end
            end
            StWrMask:   state_d = StIdle;
            StRdEdge:   state_d = StWaitEdge;
            StWaitEdge: state_d = StClrEdge;
            StClrEdge:  state_d = StRdData;
            StRdData:   state_d = StWaitData;
            StWaitData: state_d = StPush;
            StPush:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Bus registers are loaded from the next state so each bus cycle lines up with its
    // state; the first cycle after reset issues the initial mask write instead.
    always_comb begin
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = PIO_ADDR_DATA;
        wdata_d   = '0;
        if (state_q == StInitMask) begin
            cs_d      = 1'b1;
            write_n_d = 1'b0;
            addr_d    = PIO_ADDR_MASK;
            wdata_d   = PIO_BUS_W'(IRQ_MASK_INIT);
        end else begin
            unique case (state_d)
                StWrMask: begin
                    cs_d      = 1'b1;
                    write_n_d = 1'b0;
                    addr_d    = PIO_ADDR_MASK;
                    wdata_d   = PIO_BUS_W'(mask_q);
                end
                StRdEdge, StWaitEdge: begin
                    cs_d   = 1'b1;
                    addr_d = PIO_ADDR_EDGE;
                end
                StClrEdge: begin
                    cs_d      = 1'b1;
                    write_n_d = 1'b0;
                    addr_d    = PIO_ADDR_EDGE;
                end
                StRdData, StWaitData: begin
                    cs_d   = 1'b1;
                    addr_d = PIO_ADDR_DATA;
                end
                default: ;
            endcase
        end
    end

    assign has_edges = |edges_q;
    assign fifo_pop  = evt_valid & evt_ready;
    assign fifo_push = (state_q == StPush) & has_edges & (~fifo_full | fifo_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StInitMask;
            mask_q      <= '0;
            mask_pend_q <= 1'b0;
            edges_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            addr_q      <= PIO_ADDR_DATA;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            wdata_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            write_n_q <= write_n_d;
            wdata_q   <= wdata_d;
            // A new request in the WR_MASK cycle wins over the clear.
            if (cfg_mask_wr) begin
                mask_q      <= cfg_mask;
                mask_pend_q <= 1'b1;
            end else if (state_q == StWrMask) begin
                mask_pend_q <= 1'b0;
            end
            if (state_q == StWaitEdge) begin
                edges_q <= pio.pio_readdata[DATA_W-1:0];
            end
            if (state_q == StWaitData) begin
                level_q <= pio.pio_readdata[DATA_W-1:0];
            end
            if ((state_q == StPush) && has_edges && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    pio_evt_fifo #(
        .Width (RecW),
        .Depth (EVT_DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({edges_q, level_q}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid    = ~fifo_empty;
    assign evt_edges    = fifo_rdata[RecW-1:DATA_W];
    assign evt_level    = fifo_rdata[DATA_W-1:0];
    assign evt_overflow = overflow_q;
    assign busy         = (state_q != StIdle);

    assign pio.pio_address    = addr_q;
    assign pio.pio_chipselect = cs_q;
    assign pio.pio_write_n    = write_n_q;
    assign pio.pio_writedata  = wdata_q;

endmodule

// File: tb/tb_pio_sw_irq_service.sv
// Bench for pio_sw_irq_service: behavioural switch-PIO slave plus a record scoreboard.
module tb_pio_sw_irq_service;
    import pio_sw_svc_pkg::*;

    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic          clk         = 1'b0;
    logic          reset       = 1'b1;
    logic [DW-1:0] cfg_mask    = '0;
    logic          cfg_mask_wr = 1'b0;
    logic          evt_ready   = 1'b0;
    logic          evt_valid;
    logic          evt_overflow;
    logic          busy;
    logic [DW-1:0] evt_edges;
    logic [DW-1:0] evt_level;

    int errors = 0;
    int checks = 0;

    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] sb_exp;
    txn_t            log_q[$];
    txn_t            mon_t;
    int              n_mw;
    logic [31:0]     mw_data;

    logic [DW-1:0] sw        = '0;
    logic [DW-1:0] sw_prev;
    logic [DW-1:0] pio_mask;
    logic [DW-1:0] pio_edge;
    logic          force_irq = 1'b0;
    logic [31:0]   rdata;

    always #5 clk = ~clk;

    pio_sw_irq_service_if bus ();

    pio_sw_irq_service #(
        .DATA_W        (DW),
        .EVT_DEPTH     (DEPTH),
        .IRQ_MASK_INIT (4'hF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pio          (bus),
        .cfg_mask     (cfg_mask),
        .cfg_mask_wr  (cfg_mask_wr),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_edges    (evt_edges),
        .evt_level    (evt_level),
        .evt_overflow (evt_overflow),
        .busy         (busy)
    );

    // Switch PIO: rising-edge capture, clear-on-write has priority, registered readdata.
    always @(posedge clk) begin
        if (reset) begin
            pio_mask <= '0;
            pio_edge <= '0;
            sw_prev  <= sw;
            rdata    <= '0;
        end else begin
            sw_prev <= sw;
            if (bus.pio_chipselect && bus.pio_write_n) begin
                if (bus.pio_address == PIO_ADDR_EDGE)      rdata <= 32'(pio_edge);
                else if (bus.pio_address == PIO_ADDR_MASK) rdata <= 32'(pio_mask);
                else if (bus.pio_address == PIO_ADDR_DATA) rdata <= 32'(sw);
                else                                       rdata <= '0;
            end
            if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == PIO_ADDR_MASK)
                pio_mask <= bus.pio_writedata[DW-1:0];
            if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == PIO_ADDR_EDGE)
                pio_edge <= '0;
            else
                pio_edge <= pio_edge | (sw & ~sw_prev);
        end
    end

    assign bus.pio_irq      = force_irq | (|(pio_edge & pio_mask));
    assign bus.pio_readdata = rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.pio_chipselect) begin
            mon_t.we   = !bus.pio_write_n;
            mon_t.addr = bus.pio_address;
            mon_t.data = bus.pio_write_n ? 32'h0 : bus.pio_writedata;
            log_q.push_back(mon_t);
        end
    end

    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                sb_exp = exp_q.pop_front();
                check_eq("sb_rec", 64'({evt_edges, evt_level}), 64'(sb_exp));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!busy && n < 50) begin
            step();
            n++;
        end
        check_eq(tag, 64'(busy), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check_eq(tag, 64'(busy), 64'd0);
    endtask

    task automatic service(input string tag, input logic [DW-1:0] bits);
        sw = '0;
        step(2);
        sw = bits;
        wait_busy({tag, "_busy"});
        wait_idle({tag, "_idle"});
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            evt_ready = 1'b1;
            step();
            evt_ready = 1'b0;
            step();
        end
    endtask

    task automatic check_seq(input string tag);
        txn_t exp_seq[5];
        exp_seq[0] = '{we: 1'b0, addr: PIO_ADDR_EDGE, data: 32'h0};
        exp_seq[1] = '{we: 1'b0, addr: PIO_ADDR_EDGE, data: 32'h0};
        exp_seq[2] = '{we: 1'b1, addr: PIO_ADDR_EDGE, data: 32'h0};
        exp_seq[3] = '{we: 1'b0, addr: PIO_ADDR_DATA, data: 32'h0};
        exp_seq[4] = '{we: 1'b0, addr: PIO_ADDR_DATA, data: 32'h0};
        check_eq({tag, "_len"}, 64'(log_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < int'(log_q.size()))
                check_eq(tag, 64'(log_q[i]), 64'(exp_seq[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then the initial mask write in the first cycle after release.
        step(3);
        check_eq("rst_cs", 64'(bus.pio_chipselect), 64'd0);
        check_eq("rst_wn", 64'(bus.pio_write_n), 64'd1);
        check_eq("rst_addr", 64'(bus.pio_address), 64'd0);
        check_eq("rst_wd", 64'(bus.pio_writedata), 64'd0);
        check_eq("rst_valid", 64'(evt_valid), 64'd0);
        check_eq("rst_ovf", 64'(evt_overflow), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        step();
        check_eq("init_cs", 64'(bus.pio_chipselect), 64'd1);
        check_eq("init_wn", 64'(bus.pio_write_n), 64'd0);
        check_eq("init_addr", 64'(bus.pio_address), 64'd2);
        check_eq("init_wd", 64'(bus.pio_writedata), 64'h0000_000F);
        step();
        check_eq("idle_cs", 64'(bus.pio_chipselect), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("pio_mask_init", 64'(pio_mask), 64'hF);

        // Single edge event.
        log_q.delete();
        exp_q.push_back({4'b0101, 4'b0101});
        sw = 4'b0101;
        wait_busy("t2_busy");
        wait_idle("t2_idle");
        check_seq("t2_seq");
        check_eq("t2_valid", 64'(evt_valid), 64'd1);
        check_eq("t2_edges", 64'(evt_edges), 64'h5);
        check_eq("t2_level", 64'(evt_level), 64'h5);
        drain(2);
        check_eq("t2_empty", 64'(evt_valid), 64'd0);

        // Fill the FIFO, drop the fifth record, then drain in order.
        exp_q.push_back({4'b0001, 4'b0001});
        service("t3_e0", 4'b0001);
        exp_q.push_back({4'b0010, 4'b0010});
        service("t3_e1", 4'b0010);
        exp_q.push_back({4'b0100, 4'b0100});
        service("t3_e2", 4'b0100);
        exp_q.push_back({4'b1000, 4'b1000});
        service("t3_e3", 4'b1000);
        check_eq("t3_no_ovf", 64'(evt_overflow), 64'd0);
        service("t3_e4", 4'b0011);
        check_eq("t3_ovf", 64'(evt_overflow), 64'd1);
        check_eq("t3_valid", 64'(evt_valid), 64'd1);
        drain(8);
        check_eq("t3_empty", 64'(evt_valid), 64'd0);
        check_eq("t3_sb_left", 64'(exp_q.size()), 64'd0);
        check_eq("t3_ovf_sticky", 64'(evt_overflow), 64'd1);

        // Spurious irq: full bus sequence, no record.
        log_q.delete();
        force_irq = 1'b1;
        wait_busy("t4_busy");
        force_irq = 1'b0;
        wait_idle("t4_idle");
        check_seq("t4_seq");
        step(2);
        check_eq("t4_valid", 64'(evt_valid), 64'd0);

        // Mask rewrite requested mid-service lands after PUSH.
        sw = '0;
        step(2);
        log_q.delete();
        exp_q.push_back({4'b0100, 4'b0100});
        sw = 4'b0100;
        wait_busy("t5_busy");
        cfg_mask    = 4'b0010;
        cfg_mask_wr = 1'b1;
        step();
        cfg_mask_wr = 1'b0;
        wait_idle("t5_idle");
        step(4);
        n_mw    = 0;
        mw_data = '0;
        for (int i = 0; i < int'(log_q.size()); i++) begin
            if (log_q[i].we && log_q[i].addr == PIO_ADDR_MASK) begin
                n_mw++;
                mw_data = log_q[i].data;
            end
        end
        check_eq("t5_mask_wr_cnt", 64'(n_mw), 64'd1);
        check_eq("t5_mask_wr_data", 64'(mw_data), 64'd2);
        check_eq("t5_pio_mask", 64'(pio_mask), 64'd2);
        drain(2);
        check_eq("t5_empty", 64'(evt_valid), 64'd0);
        sw = '0;
        step(2);
        log_q.delete();
        sw = 4'b0001;
        step(10);
        check_eq("t5_masked_bus", 64'(log_q.size()), 64'd0);
        check_eq("t5_masked_valid", 64'(evt_valid), 64'd0);

        // The masked bit0 edge stays captured, so the first bit1 service reports 0011.
        exp_q.push_back({4'b0011, 4'b0010});
        service("t6_e0", 4'b0010);
        exp_q.push_back({4'b0010, 4'b0010});
        service("t6_e1", 4'b0010);
        sw = '0;
        step(2);
        sw = 4'b0010;
        begin
            int n = 0;
            while (dut.state_q != StWaitData && n < 50) begin
                step();
                n++;
            end
        end
        check_eq("t6_reach", 64'(dut.state_q == StWaitData), 64'd1);
        check_eq("t6_queued", 64'(evt_valid), 64'd1);
        reset = 1'b1;
        step();
        check_eq("t6_rst_valid", 64'(evt_valid), 64'd0);
        check_eq("t6_rst_cs", 64'(bus.pio_chipselect), 64'd0);
        check_eq("t6_rst_busy", 64'(busy), 64'd1);
        check_eq("t6_rst_ovf", 64'(evt_overflow), 64'd0);
        exp_q.delete();
        reset = 1'b0;
        step();
        check_eq("t6_init_cs", 64'(bus.pio_chipselect), 64'd1);
        check_eq("t6_init_wn", 64'(bus.pio_write_n), 64'd0);
        check_eq("t6_init_addr", 64'(bus.pio_address), 64'd2);
        check_eq("t6_init_wd", 64'(bus.pio_writedata), 64'h0000_000F);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
